// File: rtl/clk_edge_monitor.sv
// Multi-channel clock period/phase checker against channel 0.
// All results are counted in master_clk cycles from a common timebase.
module clk_edge_monitor #(
  parameter int NCH         = 4,
  parameter int CW          = 16,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              master_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NCH-1:0]    mon_in,
  output logic              busy,
  output logic              valid,
  output logic              timeout,
  output logic [NCH*CW-1:0] period,
  output logic [NCH*CW-1:0] phase_off,
  output logic [NCH-1:0]    freq_match,
  output logic [NCH-1:0]    phase_match
);

  typedef enum logic [1:0] {
    S_IDLE, S_MEAS, S_CMP, S_RES
  } state_t;

  localparam logic [1:0] C_W1   = 2'd0;
  localparam logic [1:0] C_W2   = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;
  localparam logic [CW:0] TOL_W = (CW+1)'(TOL);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]          hist_q, rise;
  logic [NCH-1:0]          ok, done_d;
  logic [NCH-1:0][1:0]     ch_q, ch_d;
  logic [CW-1:0]           tbase_q;
  logic [NCH-1:0][CW-1:0]  t1_q, t2_q;
  logic [NCH-1:0][CW-1:0]  per_c, ph_c, per_q, ph_q;
  logic [NCH-1:0][CW:0]    fdiff, pdiff, fmag, pmag;
  logic [NCH-1:0]          fm_c, pm_c, fm_q, pm_q;
  logic                    timeout_q, accept, tb_max;

  assign accept = (state_q == S_IDLE) && start;
  assign tb_max = &tbase_q;
  assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= mon_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_MEAS;
      S_MEAS: if (&done_d || tb_max) state_d = S_CMP;
      S_CMP:  state_d = S_RES;
      S_RES:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    valid = (state_q == S_RES);
  end

  // Per-channel edge capture: W1 -> W2 -> DONE on detected rises
  always_comb begin
    ch_d = ch_q;
    for (int i = 0; i < NCH; i++) begin
      if (accept)
        ch_d[i] = C_W1;
      else if (state_q == S_MEAS && rise[i]) begin
        case (ch_q[i])
          C_W1:    ch_d[i] = C_W2;
          C_W2:    ch_d[i] = C_DONE;
          default: ch_d[i] = ch_q[i];
        endcase
      end
      done_d[i] = (ch_d[i] == C_DONE);
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      tbase_q <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
    end else begin
      ch_q <= ch_d;
      if (accept)
        tbase_q <= '0;
      else if (state_q == S_MEAS && !tb_max)
        tbase_q <= tbase_q + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (state_q == S_MEAS && rise[i]) begin
          if (ch_q[i] == C_W1) t1_q[i] <= tbase_q;
          if (ch_q[i] == C_W2) t2_q[i] <= tbase_q;
        end
      end
    end
  end

  // Differences are taken one bit wider so wrap never fakes a match
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ok[i]    = (ch_q[i] == C_DONE);
      per_c[i] = ok[i] ? (t2_q[i] - t1_q[i]) : '0;
    end
    for (int i = 0; i < NCH; i++) begin
      fdiff[i] = {1'b0, per_c[i]} - {1'b0, per_c[0]};
      pdiff[i] = {1'b0, t1_q[i]} - {1'b0, t1_q[0]};
      fmag[i]  = fdiff[i][CW] ? -fdiff[i] : fdiff[i];
      pmag[i]  = pdiff[i][CW] ? -pdiff[i] : pdiff[i];
      ph_c[i]  = (ok[i] && ok[0]) ? pdiff[i][CW-1:0] : '0;
      fm_c[i]  = ok[i] && ok[0] && (fmag[i] <= TOL_W);
      pm_c[i]  = ok[i] && ok[0] && (pmag[i] <= TOL_W);
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q     <= '0;
      ph_q      <= '0;
      fm_q      <= '0;
      pm_q      <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if (state_q == S_CMP) begin
      per_q     <= per_c;
      ph_q      <= ph_c;
      fm_q      <= fm_c;
      pm_q      <= pm_c;
      timeout_q <= ~&ok;
    end
  end

  assign period      = per_q;
  assign phase_off   = ph_q;
  assign freq_match  = fm_q;
  assign phase_match = pm_q;
  assign timeout     = timeout_q;

endmodule
